// File: rtl/router_pkt_tx.sv
// router_pkt_tx: transmit end of the router byte protocol.
// Stages up to 63 payload bytes, then sends header {len, addr}, the payload
// and an XOR parity byte, honouring the router's busy flow control and
// aborting if busy stays high for TIMEOUT_CYC consecutive cycles on one byte.
module router_pkt_tx #(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       buf_we,
   input  logic [7:0] buf_wdata,
   input  logic       start,
   input  logic [1:0] dest_addr,
   input  logic [5:0] pkt_len,
   input  logic       busy,
   output logic [7:0] data_out,
   output logic       pkt_valid,
   output logic       tx_active,
   output logic [6:0] buf_count,
   output logic       done,
   output logic       err
);

   localparam logic [9:0] TMO_LIM = 10'(TIMEOUT_CYC);

   typedef enum logic [1:0] {IDLE, HDR, PLD, PAR} state_t;

   state_t     state_q, state_d;
   logic [7:0] data_out_q, data_out_d;
   logic       pkt_valid_q, pkt_valid_d;
   logic       tx_active_q, tx_active_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic [6:0] buf_count_q, buf_count_d;
   logic [7:0] parity_q, parity_d;
   logic [9:0] tmo_q, tmo_d;
   logic [5:0] rd_ptr_q, rd_ptr_d;
   logic [5:0] len_q, len_d;

   logic [7:0] mem [0:63];
   logic       mem_we;
   logic [9:0] tmo_inc;
   logic       start_ok;

   // Next-state and output logic: staging in IDLE, byte advance on accept, timeout abort.
   always_comb begin
      state_d     = state_q;
      data_out_d  = data_out_q;
      pkt_valid_d = pkt_valid_q;
      tx_active_d = tx_active_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      buf_count_d = buf_count_q;
      parity_d    = parity_q;
      tmo_d       = tmo_q;
      rd_ptr_d    = rd_ptr_q;
      len_d       = len_q;
      mem_we      = 1'b0;
      tmo_inc     = tmo_q + 10'd1;
      // Start is judged against the count before any same-cycle write.
      start_ok    = (dest_addr != 2'd3) && (pkt_len != 6'd0) &&
                    ({1'b0, pkt_len} <= buf_count_q);

      if (state_q == IDLE) begin
         if (buf_we && (buf_count_q < 7'd63)) begin
            mem_we      = 1'b1;
            buf_count_d = buf_count_q + 7'd1;
         end
         if (start) begin
            if (start_ok) begin
               len_d       = pkt_len;
               rd_ptr_d    = 6'd0;
               parity_d    = 8'd0;
               tmo_d       = 10'd0;
               data_out_d  = {pkt_len, dest_addr};
               pkt_valid_d = 1'b1;
               tx_active_d = 1'b1;
               state_d     = HDR;
            end else begin
               err_d = 1'b1;
            end
         end
      end else if (busy) begin
         tmo_d = tmo_inc;
         if (tmo_inc == TMO_LIM) begin
            // Router has stalled this byte too long: drop the packet.
            tmo_d       = 10'd0;
            data_out_d  = 8'd0;
            pkt_valid_d = 1'b0;
            tx_active_d = 1'b0;
            err_d       = 1'b1;
            buf_count_d = 7'd0;
            state_d     = IDLE;
         end
      end else begin
         tmo_d = 10'd0;
         if (state_q == HDR) begin
            parity_d   = parity_q ^ data_out_q;
            data_out_d = mem[0];
            rd_ptr_d   = 6'd0;
            state_d    = PLD;
         end else if (state_q == PLD) begin
            parity_d = parity_q ^ data_out_q;
            rd_ptr_d = rd_ptr_q + 6'd1;
            if (rd_ptr_q == (len_q - 6'd1)) begin
               // Parity covers the header and every payload byte, this one included.
               data_out_d  = parity_q ^ data_out_q;
               pkt_valid_d = 1'b0;
               state_d     = PAR;
            end else begin
               data_out_d = mem[rd_ptr_q + 6'd1];
            end
         end else begin
            data_out_d  = 8'd0;
            tx_active_d = 1'b0;
            done_d      = 1'b1;
            buf_count_d = 7'd0;
            state_d     = IDLE;
         end
      end
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         data_out_q  <= 8'd0;
         pkt_valid_q <= 1'b0;
         tx_active_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         buf_count_q <= 7'd0;
         parity_q    <= 8'd0;
         tmo_q       <= 10'd0;
      end else begin
         state_q     <= state_d;
         data_out_q  <= data_out_d;
         pkt_valid_q <= pkt_valid_d;
         tx_active_q <= tx_active_d;
         done_q      <= done_d;
         err_q       <= err_d;
         buf_count_q <= buf_count_d;
         parity_q    <= parity_d;
         tmo_q       <= tmo_d;
      end
   end

   // Packet bookkeeping; only meaningful once a start has loaded them.
   always_ff @(posedge clk) begin
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
   end

   // Payload staging buffer.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[buf_count_q[5:0]] <= buf_wdata;
      end
   end

   assign data_out  = data_out_q;
   assign pkt_valid = pkt_valid_q;
   assign tx_active = tx_active_q;
   assign buf_count = buf_count_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: a queue-based model of the byte stream checked
// against the DUT every cycle, plus directed literal checks.
module tb_router_pkt_tx;
   localparam int TMO = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       buf_we = 1'b0;
   logic [7:0] buf_wdata = 8'd0;
   logic       start = 1'b0;
   logic [1:0] dest_addr = 2'd0;
   logic [5:0] pkt_len = 6'd0;
   logic       busy = 1'b0;
   logic [7:0] data_out;
   logic       pkt_valid, tx_active, done, err;
   logic [6:0] buf_count;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // Model state: staged bytes, remaining bytes of the packet in flight.
   byte unsigned m_buf[$];
   byte unsigned m_tx[$];
   int           m_run = 0;
   int           e_data = 0, e_pv = 0, e_act = 0, e_done = 0, e_err = 0, e_cnt = 0;

   always #5 clk = ~clk;

   router_pkt_tx #(.TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst), .buf_we(buf_we), .buf_wdata(buf_wdata),
      .start(start), .dest_addr(dest_addr), .pkt_len(pkt_len), .busy(busy),
      .data_out(data_out), .pkt_valid(pkt_valid), .tx_active(tx_active),
      .buf_count(buf_count), .done(done), .err(err)
   );

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      byte unsigned p;
      e_done = 0;
      e_err  = 0;
      if (rst) begin
         m_tx.delete();
         m_buf.delete();
         m_run  = 0;
         e_data = 0;
      end else if (m_tx.size() == 0) begin
         if (start) begin
            if (dest_addr == 2'd3 || pkt_len == 6'd0 || int'(pkt_len) > m_buf.size()) begin
               e_err = 1;
            end else begin
               p = {pkt_len, dest_addr};
               m_tx.push_back(p);
               for (int i = 0; i < int'(pkt_len); i++) begin
                  m_tx.push_back(m_buf[i]);
                  p = p ^ m_buf[i];
               end
               m_tx.push_back(p);
               e_data = m_tx[0];
               m_run  = 0;
            end
         end
         if (buf_we && m_buf.size() < 63) m_buf.push_back(buf_wdata);
      end else if (!busy) begin
         m_run = 0;
         void'(m_tx.pop_front());
         if (m_tx.size() == 0) begin
            e_done = 1;
            e_data = 0;
            m_buf.delete();
         end else begin
            e_data = m_tx[0];
         end
      end else begin
         m_run++;
         if (m_run == TMO) begin
            m_tx.delete();
            m_buf.delete();
            m_run  = 0;
            e_err  = 1;
            e_data = 0;
         end
      end
      e_pv  = (m_tx.size() > 1) ? 1 : 0;
      e_act = (m_tx.size() > 0) ? 1 : 0;
      e_cnt = m_buf.size();
   endtask

   // Model advances on every active edge using the inputs sampled there.
   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Compare DUT against the model on every falling edge.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("m_data_out",  32'(data_out),  e_data);
         chk("m_pkt_valid", 32'(pkt_valid), e_pv);
         chk("m_tx_active", 32'(tx_active), e_act);
         chk("m_done",      32'(done),      e_done);
         chk("m_err",       32'(err),       e_err);
         chk("m_buf_count", 32'(buf_count), e_cnt);
      end
   end

   task automatic wr(input logic [7:0] b);
      buf_we    = 1'b1;
      buf_wdata = b;
      @(negedge clk);
      buf_we    = 1'b0;
   endtask

   // Pulses start for one edge; returns at the falling edge after it.
   task automatic send(input logic [1:0] a, input logic [5:0] l);
      start     = 1'b1;
      dest_addr = a;
      pkt_len   = l;
      @(negedge clk);
      start     = 1'b0;
   endtask

   initial begin
      int n;
      int ndone;
      int par;

      // Reset
      @(negedge clk);
      chk("rst_data_out",  32'(data_out),  0);
      chk("rst_pkt_valid", 32'(pkt_valid), 0);
      chk("rst_tx_active", 32'(tx_active), 0);
      chk("rst_buf_count", 32'(buf_count), 0);
      chk("rst_done_err",  32'({done, err}), 0);
      chk_en = 1'b1;
      rst    = 1'b0;
      @(negedge clk);

      // 1: basic packet, no busy
      wr(8'h11); wr(8'h22); wr(8'h33);
      chk("t1_count", 32'(buf_count), 3);
      send(2'd1, 6'd3);
      chk("t1_hdr", 32'(data_out), 'h0D);
      chk("t1_hdr_pv", 32'(pkt_valid), 1);
      @(negedge clk); chk("t1_b0", 32'(data_out), 'h11);
      @(negedge clk); chk("t1_b1", 32'(data_out), 'h22);
      @(negedge clk); chk("t1_b2", 32'(data_out), 'h33);
      @(negedge clk); chk("t1_par", 32'(data_out), 'h0D);
      chk("t1_par_pv", 32'(pkt_valid), 0);
      @(negedge clk); chk("t1_done", 32'(done), 1);
      chk("t1_count0", 32'(buf_count), 0);

      // 2: header held by busy for three edges
      wr(8'h11); wr(8'h22); wr(8'h33);
      send(2'd1, 6'd3);
      busy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t2_hdr_hold", 32'(data_out), 'h0D);
      end
      busy = 1'b0;
      @(negedge clk); chk("t2_b0", 32'(data_out), 'h11);
      repeat (4) @(negedge clk);
      chk("t2_done", 32'(done), 1);

      // 3: rejected starts
      wr(8'hA5); wr(8'h5A);
      send(2'd3, 6'd1);
      chk("t3_err_addr", 32'({err, pkt_valid}), 'b10);
      send(2'd0, 6'd0);
      chk("t3_err_len0", 32'({err, pkt_valid}), 'b10);
      send(2'd1, 6'd5);
      chk("t3_err_long", 32'({err, pkt_valid}), 'b10);
      chk("t3_count", 32'(buf_count), 2);

      // 4: stuck busy timeout
      send(2'd2, 6'd2);
      @(negedge clk);
      chk("t4_b0", 32'(data_out), 'hA5);
      busy = 1'b1;
      n = 0;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (err) begin
            n = k;
            break;
         end
      end
      chk("t4_tmo_cycles", 32'(n), TMO);
      chk("t4_tmo_state", 32'({pkt_valid, tx_active, buf_count}), 0);
      busy = 1'b0;
      @(negedge clk);
      chk("t4_err_pulse", 32'(err), 0);

      // 5: full buffer, busy toggling
      for (int i = 0; i < 63; i++) wr(8'(i));
      wr(8'h77);
      chk("t5_count_full", 32'(buf_count), 63);
      send(2'd2, 6'd63);
      chk("t5_hdr", 32'(data_out), 'hFE);
      ndone = 0;
      par = -1;
      for (int k = 0; k < 400; k++) begin
         busy = ~busy;
         @(negedge clk);
         if (tx_active && !pkt_valid) par = int'(data_out);
         if (done) begin
            ndone++;
            break;
         end
      end
      busy = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("t5_parity", 32'(par), 'hC1);
      chk("t5_done_once", 32'(ndone), 1);

      // 6: reset mid-packet, then a clean packet
      wr(8'hA1); wr(8'hB2); wr(8'hC3);
      send(2'd0, 6'd3);
      @(negedge clk);
      @(negedge clk);
      chk("t6_b1", 32'(data_out), 'hB2);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_out", 32'({data_out, pkt_valid, tx_active, buf_count}), 0);
      rst = 1'b0;
      wr(8'h01); wr(8'h02); wr(8'h04);
      send(2'd2, 6'd3);
      chk("t6_hdr", 32'(data_out), 'h0E);
      repeat (4) @(negedge clk);
      chk("t6_par", 32'(data_out), 'h09);
      @(negedge clk);
      chk("t6_done", 32'(done), 1);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
- Packet source that drives the router's input port: the transmit end of the header/payload/parity byte protocol the router FSM receives.
- Payload is staged into an internal 64-byte buffer, then sent on start as: header {len[5:0], addr[1:0]}, len payload bytes, parity byte.
- Honours the router's busy flow control and aborts on a stuck-busy timeout.
- Used as the bench stimulus engine and as the host-side injector.

Parameters:
TIMEOUT_CYC, 64, consecutive busy-high cycles on one byte before abort (range 2..1023)

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous active-high reset
buf_we  in  1  write buf_wdata into payload buffer at write pointer
buf_wdata  in  8  payload byte
start  in  1  request to send staged packet
dest_addr  in  2  destination port 0..2; 3 is invalid
pkt_len  in  6  payload length 1..63
busy  in  1  router busy; byte on data_out is not consumed while high
data_out  out  8  byte to router data_in
pkt_valid  out  1  high during header and payload, low during parity
tx_active  out  1  packet in flight
buf_count  out  7  bytes currently staged (0..63)
done  out  1  one-cycle pulse when parity byte is accepted
err  out  1  one-cycle pulse on rejected start or timeout abort

Behaviour:
- Reset (rst=1 at posedge): state IDLE, data_out=0, pkt_valid=0, tx_active=0, done=0, err=0, buf_count=0, parity accumulator=0, timeout counter=0. Buffer contents are don't-care.
- All outputs are registered.
- States: IDLE, HDR, PLD, PAR.
- Accept rule: in HDR, PLD or PAR, the byte on data_out is consumed at a posedge where busy==0. Otherwise data_out and pkt_valid hold.
- Buffer write:
  - buf_we in IDLE with buf_count<63 writes entry[buf_count]; buf_count increments.
  - Writes at count 63 are dropped.
  - Writes outside IDLE are ignored.
- Start handling (IDLE only; ignored in other states):
  - Reject if dest_addr==3, pkt_len==0, or pkt_len>buf_count. Reject gives err=1 next cycle, stays IDLE, buffer unchanged.
  - Accept latches addr and len, read pointer=0, parity=0. Next cycle: state HDR, data_out={pkt_len,dest_addr}, pkt_valid=1, tx_active=1.
  - If start and buf_we occur in the same IDLE cycle, start is evaluated against the pre-write buf_count and the write still occurs.
- HDR, on accept: parity^=header; data_out=entry[0]; state PLD.
- PLD, on accept:
  - parity^=current byte; read pointer increments.
  - If this was byte len-1: data_out=parity (including this byte), pkt_valid=0, state PAR.
  - Else data_out=next entry.
- PAR, on accept: data_out=0, tx_active=0, done=1 for one cycle, buf_count=0, state IDLE.
- Timeout:
  - Counter increments each cycle busy==1 in HDR/PLD/PAR and clears on every accept.
  - When it reaches TIMEOUT_CYC: data_out=0, pkt_valid=0, tx_active=0, err=1 pulse, buf_count=0, state IDLE.
- Minimum latency from start to header on data_out is 1 cycle. With busy always 0, a len-N packet occupies N+2 consecutive cycles and done fires at start+N+3.
- A new start is accepted at the earliest in the cycle done is high, after buffer reload.
- rst mid-packet: next cycle all outputs at reset values. Nothing further is driven, so the router sees pkt_valid drop.

Test Plan:
1. Load 0x11,0x22,0x33; start addr=1 len=3; busy=0 at T → data_out 0x0D@T+1, 0x11@T+2, 0x22@T+3, 0x33@T+4 with pkt_valid=1; parity 0x0D@T+5 with pkt_valid=0; done=1@T+6; buf_count=0.
2. Same packet, busy=1 for cycles T+1..T+3 → header held 4 cycles, payload starts T+5, done@T+9, no err.
3. start with dest_addr=3, then with len=0, then with len=5 and buf_count=2 → err pulse each time, pkt_valid stays 0, buf_count unchanged.
4. busy stuck high from T+2 with TIMEOUT_CYC=64 → at the 64th busy cycle pkt_valid=0, err=1 for one cycle, tx_active=0, buf_count=0.
5. Load 63 bytes 0x00..0x3E, then a 64th write → buf_count stays 63. Send addr=2 len=63 with busy toggling every cycle → header 0xFE, all 63 bytes in order, parity equal to XOR of all 64 bytes, done once.
6. rst asserted during the 2nd payload byte → next cycle data_out=0, pkt_valid=0, tx_active=0, buf_count=0. A subsequent full packet sends correctly.
